cdec_bus_shell: RTL and testbench
=================================

# cdec_bus_shell

Parametrised memory/IO shell for the CDEC-family CPU cores. It replaces the fixed core-to-RAM hookup with a handshaked bus of configurable data and address widths, built from four parts: an inferred synchronous RAM, a bank of memory-mapped I/O channels, a programmable wait-state generator and a registered debug-monitor readback. It sits directly between the CPU core bus and the board/top-level pins.

## Interface
- DATA_W, 8, bus/word width
- ADDR_W, 8, CPU address width
- RAM_DEPTH, 128, RAM words at addresses 0..RAM_DEPTH-1
- IO_BASE, 8'hF0, first I/O channel address; IO_BASE >= RAM_DEPTH
- NUM_CH, 4, I/O channels (1..8); IO_BASE+NUM_CH < 2^ADDR_W
- WAIT_STATES, 1, extra cycles per access (0..15)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_adrs  in  ADDR_W  access address
- cpu_wdata  in  DATA_W  write data
- cpu_rd  in  1  read request, held until cpu_ready
- cpu_wr  in  1  write request, held until cpu_ready
- cpu_rdata  out  DATA_W  read data, valid while cpu_ready=1
- cpu_ready  out  1  one-cycle access completion
- io_out  out  NUM_CH*DATA_W  output channel registers; channel k at bits [k*DATA_W +: DATA_W]
- io_wstb  out  NUM_CH  one-cycle write strobe per channel
- io_in  in  NUM_CH*DATA_W  asynchronous input channels
- bus_err  out  1  sticky error flag
- resad  in  8  debug monitor select
- resdt  out  DATA_W  debug monitor data, registered

## Operation
- Address map:
  - 0..RAM_DEPTH-1: RAM.
  - IO_BASE+k, k<NUM_CH: channel k. A write updates io_out[k]. A read returns synchronised io_in[k].
  - IO_BASE+NUM_CH: status register. Reads return {0…, bus_err}. Writing with bit0=1 clears bus_err.
  - Anything else is unmapped. Reads return 0, writes are dropped, and bus_err is set.
- FSM states:
  - IDLE: cpu_rd xor cpu_wr sampled high → latch address, data and op; go to WAIT if WAIT_STATES>0, else DONE. cpu_rd and cpu_wr both high → set bus_err, no access, stay IDLE.
  - WAIT: counter loads WAIT_STATES-1 and decrements; go to DONE after it reaches 0.
  - DONE: cpu_ready=1 for exactly one cycle, then IDLE.
- A request still asserted in the IDLE cycle after DONE starts a new access, so back-to-back accesses are legal.
- Request changes during WAIT are ignored; the latched values are used.
- Writes (RAM, io_out, status clear) commit on the edge entering DONE. The io_wstb bit for the written channel is high during the DONE cycle only.
- cpu_rdata:
  - Loaded on the edge entering DONE.
  - Holds until the next read completes; write completions leave it unchanged.
  - Driven 0 for unmapped reads.
- io_in: every bit passes through a 2-flop synchroniser before read or monitor.
- Debug monitor, resdt registered from resad (1-cycle latency):
  - 0x00+k: io_out[k].
  - 0x40+k: synchronised io_in[k].
  - 0x80: {bus_err, state[1:0]} LSB-aligned.
  - 0x81: latched address, zero-extended or truncated to DATA_W.
  - Anything else: 0.
- Reset (asynchronous, any time):
  - State → IDLE.
  - cpu_ready, cpu_rdata, io_out, io_wstb, bus_err, resdt, synchronisers and wait counter → 0.
  - An access interrupted before its commit edge leaves no write.
  - RAM contents are not reset.

## Timing
- Request sampled at edge N. cpu_ready is high in cycle N+1+WAIT_STATES; the write commits and the read data loads at that cycle's starting edge.
- Access period is WAIT_STATES+2 cycles when requests are held continuously.
- io_in to readable value: 2 edges.
- resad to resdt: 1 edge.
- bus_err sets at the edge entering DONE for unmapped accesses, or at the sampling edge for a rd+wr conflict.
- When an error set and a status clear land on the same edge, set wins.

## Test plan
Default parameters unless stated.
- Write 0x5A to 0x10, then read 0x10 → cpu_ready exactly 2 cycles after each request; the read returns 0x5A; io_wstb stays 0.
- Write 0xC3 to 0xF2 → io_out[2]=0xC3 in the ready cycle; io_wstb=4'b0100 for one cycle; resad=0x02 gives resdt=0xC3 one cycle later.
- Drive io_in[1]=0x77, wait 2 cycles, read 0xF1 → 0x77. Change io_in one cycle before the read's data-load edge → previous value returned.
- Read 0xA0 → cpu_rdata=0, bus_err=1. Write 0x01 to 0xF4 → bus_err=0. Assert rd and wr together → bus_err=1, no cpu_ready.
- WAIT_STATES=0, held read of 0x00..0x03 → cpu_ready pulses every 2 cycles and data matches pre-written RAM.
- Assert reset during WAIT of a write to 0xF0 → io_out[0] stays 0, and all outputs are 0 while reset is high.

Source files
------------

// File: rtl/cdec_bus_shell_if.sv
// cdec_bus_shell_if: CPU-side handshaked bus between a CDEC core and its memory/IO shell.
//   cpu_adrs  : access address (master -> slave)
//   cpu_wdata : write data (master -> slave)
//   cpu_rd    : read request, held until cpu_ready (master -> slave)
//   cpu_wr    : write request, held until cpu_ready (master -> slave)
//   cpu_rdata : read data, valid while cpu_ready=1 (slave -> master)
//   cpu_ready : one-cycle access completion (slave -> master)
interface cdec_bus_shell_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 8
);
   logic [ADDR_W-1:0] cpu_adrs;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_rd;
   logic              cpu_wr;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_ready;

   modport master (
      output cpu_adrs, cpu_wdata, cpu_rd, cpu_wr,
      input  cpu_rdata, cpu_ready
   );

   modport slave (
      input  cpu_adrs, cpu_wdata, cpu_rd, cpu_wr,
      output cpu_rdata, cpu_ready
   );
endinterface

// File: rtl/cdec_bus_shell.sv
// cdec_bus_shell: memory/IO shell for CDEC cores. Inferred RAM, memory-mapped I/O channels,
// a status register, a programmable wait-state generator and a registered debug monitor.
//   clock   : system clock, rising edge
//   reset   : asynchronous active-high reset
//   bus     : CPU bus (slave modport of cdec_bus_shell_if)
//   io_out  : output channel registers, channel k at [k*DATA_W +: DATA_W]
//   io_wstb : one-cycle write strobe per channel
//   io_in   : asynchronous input channels (2-flop synchronised)
//   bus_err : sticky error flag (unmapped access or rd+wr conflict)
//   resad   : debug monitor select
//   resdt   : debug monitor data, one cycle after resad
module cdec_bus_shell #(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned RAM_DEPTH   = 128,
   parameter int unsigned IO_BASE     = 'hF0,
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic                     clock,
   input  logic                     reset,
   cdec_bus_shell_if.slave          bus,
   output logic [NUM_CH*DATA_W-1:0] io_out,
   output logic [NUM_CH-1:0]        io_wstb,
   input  logic [NUM_CH*DATA_W-1:0] io_in,
   output logic                     bus_err,
   input  logic [7:0]               resad,
   output logic [DATA_W-1:0]        resdt
);
   localparam int unsigned RamAw = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

   typedef enum logic [1:0] {StIdle = 2'd0, StWait = 2'd1, StDone = 2'd2} state_e;

   state_e                    state_q, state_d;
   logic [3:0]                wcnt_q, wcnt_d;
   logic [ADDR_W-1:0]         adr_q, adr_d;
   logic [DATA_W-1:0]         wdat_q, wdat_d;
   logic                      wr_q, wr_d;
   logic                      err_q, err_d;
   logic [DATA_W-1:0]         rdata_q, rdata_d;
   logic [NUM_CH-1:0]         wstb_q, wstb_d;
   logic [DATA_W-1:0]         out_q [NUM_CH];
   logic [DATA_W-1:0]         out_d [NUM_CH];
   logic [NUM_CH*DATA_W-1:0]  sync1_q, sync2_q;
   logic [DATA_W-1:0]         resdt_q, resdt_d;
   logic [DATA_W-1:0]         mem [RAM_DEPTH];

   logic                      commit, conflict, err_set, ram_we;
   logic [ADDR_W-1:0]         acc_adr;
   logic [DATA_W-1:0]         acc_wdat;
   logic                      acc_wr;
   logic [31:0]               adr32, ch_off;
   logic                      is_ram, is_io, is_stat;
   logic [RamAw-1:0]          ram_idx;

   // The commit edge out of IDLE (zero wait states) must use the live request; otherwise the
   // values latched at the sampling edge are used.
   always_comb begin
      acc_adr  = adr_q;
      acc_wdat = wdat_q;
      acc_wr   = wr_q;
      if (state_q == StIdle) begin
         acc_adr  = bus.cpu_adrs;
         acc_wdat = bus.cpu_wdata;
         acc_wr   = bus.cpu_wr;
      end
   end

   assign adr32   = 32'(acc_adr);
   assign ch_off  = adr32 - IO_BASE;
   assign is_ram  = adr32 < RAM_DEPTH;
   assign is_io   = (adr32 >= IO_BASE) && (adr32 < IO_BASE + NUM_CH);
   assign is_stat = adr32 == IO_BASE + NUM_CH;
   assign ram_idx = acc_adr[RamAw-1:0];

   // Access FSM
   always_comb begin
      state_d  = state_q;
      wcnt_d   = wcnt_q;
      adr_d    = adr_q;
      wdat_d   = wdat_q;
      wr_d     = wr_q;
      commit   = 1'b0;
      conflict = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.cpu_rd ^ bus.cpu_wr) begin
               adr_d  = bus.cpu_adrs;
               wdat_d = bus.cpu_wdata;
               wr_d   = bus.cpu_wr;
               if (WAIT_STATES > 0) begin
                  state_d = StWait;
                  wcnt_d  = 4'(WAIT_STATES - 1);
               end else begin
                  state_d = StDone;
                  commit  = 1'b1;
               end
            end else if (bus.cpu_rd && bus.cpu_wr) begin
               conflict = 1'b1;
            end
         end
         StWait: begin
            if (wcnt_q == 4'd0) begin
               state_d = StDone;
               commit  = 1'b1;
            end else begin
               wcnt_d = wcnt_q - 4'd1;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Datapath effects of the commit edge
   always_comb begin
      rdata_d = rdata_q;
      err_d   = err_q;
      err_set = conflict;
      wstb_d  = '0;
      ram_we  = 1'b0;
      for (int k = 0; k < NUM_CH; k++) out_d[k] = out_q[k];
      if (commit) begin
         if (acc_wr) begin
            if (is_ram) begin
               ram_we = 1'b1;
            end else if (is_io) begin
               for (int k = 0; k < NUM_CH; k++) begin
                  if (ch_off == 32'(k)) begin
                     out_d[k]  = acc_wdat;
                     wstb_d[k] = 1'b1;
                  end
               end
            end else if (is_stat) begin
               if (acc_wdat[0]) err_d = 1'b0;
            end else begin
               err_set = 1'b1;
            end
         end else begin
            rdata_d = '0;
            if (is_ram) begin
               rdata_d = mem[ram_idx];
            end else if (is_io) begin
               for (int k = 0; k < NUM_CH; k++) begin
                  if (ch_off == 32'(k)) rdata_d = sync2_q[k*DATA_W +: DATA_W];
               end
            end else if (is_stat) begin
               rdata_d = {{(DATA_W-1){1'b0}}, err_q};
            end else begin
               err_set = 1'b1;
            end
         end
      end
      // A simultaneous set outranks a status clear.
      if (err_set) err_d = 1'b1;
   end

   // Debug monitor select
   always_comb begin
      resdt_d = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (resad == 8'(k))        resdt_d = out_q[k];
         if (resad == 8'(64 + k))   resdt_d = sync2_q[k*DATA_W +: DATA_W];
      end
      if (resad == 8'h80) resdt_d = DATA_W'({err_q, state_q});
      if (resad == 8'h81) resdt_d = DATA_W'(adr_q);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         wcnt_q  <= '0;
         adr_q   <= '0;
         wdat_q  <= '0;
         wr_q    <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         wstb_q  <= '0;
         sync1_q <= '0;
         sync2_q <= '0;
         resdt_q <= '0;
         for (int k = 0; k < NUM_CH; k++) out_q[k] <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         adr_q   <= adr_d;
         wdat_q  <= wdat_d;
         wr_q    <= wr_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         wstb_q  <= wstb_d;
         sync1_q <= io_in;
         sync2_q <= sync1_q;
         resdt_q <= resdt_d;
         for (int k = 0; k < NUM_CH; k++) out_q[k] <= out_d[k];
      end
   end

   // RAM contents survive reset.
   always_ff @(posedge clock) begin
      if (ram_we) mem[ram_idx] <= acc_wdat;
   end

   always_comb begin
      for (int k = 0; k < NUM_CH; k++) io_out[k*DATA_W +: DATA_W] = out_q[k];
   end

   assign io_wstb       = wstb_q;
   assign bus_err       = err_q;
   assign resdt         = resdt_q;
   assign bus.cpu_rdata = rdata_q;
   assign bus.cpu_ready = (state_q == StDone);
endmodule

// File: tb/tb_cdec_bus_shell.sv
// Bench for cdec_bus_shell: one instance with one wait state, one with none.
module tb_cdec_bus_shell;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cdec_bus_shell_if #(.DATA_W(8), .ADDR_W(8)) bif ();
   cdec_bus_shell_if #(.DATA_W(8), .ADDR_W(8)) bif0 ();

   logic [31:0] io_out, io_out0, io_in, io_in0;
   logic [3:0]  io_wstb, io_wstb0;
   logic        bus_err, bus_err0;
   logic [7:0]  resad, resdt, resdt0;

   cdec_bus_shell #(.WAIT_STATES(1)) dut (
      .clock(clk), .reset(rst), .bus(bif), .io_out(io_out), .io_wstb(io_wstb),
      .io_in(io_in), .bus_err(bus_err), .resad(resad), .resdt(resdt)
   );

   cdec_bus_shell #(.WAIT_STATES(0)) dut0 (
      .clock(clk), .reset(rst), .bus(bif0), .io_out(io_out0), .io_wstb(io_wstb0),
      .io_in(io_in0), .bus_err(bus_err0), .resad(resad), .resdt(resdt0)
   );

   int errors = 0;
   int checks = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp0_q[$];
   logic [7:0] last_rd  = 8'h00;
   logic [7:0] last_rd0 = 8'h00;
   logic ram_phase = 1'b0;
   logic wstb_seen = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitors: every completion pops one expected cpu_rdata.
   always @(negedge clk) begin
      if (!rst && bif.cpu_ready) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ready: got ready expected none");
         end else chk("rdata", 32'(bif.cpu_rdata), 32'(exp_q.pop_front()));
      end
   end

   always @(negedge clk) begin
      if (!rst && bif0.cpu_ready) begin
         if (exp0_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ready0: got ready expected none");
         end else chk("rdata0", 32'(bif0.cpu_rdata), 32'(exp0_q.pop_front()));
      end
   end

   always @(negedge clk) if (ram_phase && io_wstb != 4'b0) wstb_seen = 1'b1;

   // Returns at the negedge inside the ready cycle.
   task automatic acc(input logic rd, input logic [7:0] a, input logic [7:0] d,
                      input logic [7:0] rexp);
      int n;
      @(negedge clk);
      bif.cpu_adrs = a; bif.cpu_wdata = d; bif.cpu_rd = rd; bif.cpu_wr = !rd;
      if (rd) last_rd = rexp;
      exp_q.push_back(last_rd);
      n = 0;
      do begin @(negedge clk); n++; end while (!bif.cpu_ready && n < 20);
      chk("latency", n, 2);
      bif.cpu_rd = 1'b0; bif.cpu_wr = 1'b0;
   endtask

   task automatic acc0(input logic rd, input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] rexp);
      int n;
      @(negedge clk);
      bif0.cpu_adrs = a; bif0.cpu_wdata = d; bif0.cpu_rd = rd; bif0.cpu_wr = !rd;
      if (rd) last_rd0 = rexp;
      exp0_q.push_back(last_rd0);
      n = 0;
      do begin @(negedge clk); n++; end while (!bif0.cpu_ready && n < 20);
      chk("latency0", n, 1);
      bif0.cpu_rd = 1'b0; bif0.cpu_wr = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] held_data [4];
      held_data[0] = 8'h11; held_data[1] = 8'h22; held_data[2] = 8'h33; held_data[3] = 8'h44;
      bif.cpu_adrs = '0; bif.cpu_wdata = '0; bif.cpu_rd = 1'b0; bif.cpu_wr = 1'b0;
      bif0.cpu_adrs = '0; bif0.cpu_wdata = '0; bif0.cpu_rd = 1'b0; bif0.cpu_wr = 1'b0;
      io_in = '0; io_in0 = '0; resad = 8'h00;
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(bif.cpu_ready), 0);
      chk("rst_rdata", 32'(bif.cpu_rdata), 0);
      chk("rst_io_out", io_out, 0);
      chk("rst_wstb", 32'(io_wstb), 0);
      chk("rst_bus_err", 32'(bus_err), 0);
      chk("rst_resdt", 32'(resdt), 0);
      rst = 1'b0;

      // RAM write then read
      ram_phase = 1'b1;
      acc(1'b0, 8'h10, 8'h5A, 8'h00);
      acc(1'b1, 8'h10, 8'h00, 8'h5A);
      ram_phase = 1'b0;
      chk("ram_wstb_quiet", 32'(wstb_seen), 0);

      // I/O channel write, strobe and monitor readback
      acc(1'b0, 8'hF2, 8'hC3, 8'h00);
      chk("io_out2", 32'(io_out[23:16]), 32'h0000_00C3);
      chk("wstb_pulse", 32'(io_wstb), 32'h4);
      @(negedge clk);
      chk("wstb_drop", 32'(io_wstb), 0);
      resad = 8'h02;
      @(negedge clk);
      chk("resdt_out2", 32'(resdt), 32'h0000_00C3);

      // Synchronised input read, then change one cycle before the data-load edge
      io_in[15:8] = 8'h77;
      repeat (2) @(negedge clk);
      acc(1'b1, 8'hF1, 8'h00, 8'h77);
      fork
         acc(1'b1, 8'hF1, 8'h00, 8'h77);
         begin @(negedge clk); io_in[15:8] = 8'h11; end
      join
      repeat (2) @(negedge clk);
      acc(1'b1, 8'hF1, 8'h00, 8'h11);
      resad = 8'h41;
      @(negedge clk);
      chk("resdt_in1", 32'(resdt), 32'h11);

      // Errors: unmapped read, status read/clear, rd+wr conflict
      acc(1'b1, 8'hA0, 8'h00, 8'h00);
      chk("err_unmapped", 32'(bus_err), 1);
      acc(1'b1, 8'hF4, 8'h00, 8'h01);
      acc(1'b0, 8'hF4, 8'h01, 8'h00);
      chk("err_clear", 32'(bus_err), 0);
      @(negedge clk);
      bif.cpu_rd = 1'b1; bif.cpu_wr = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("conflict_no_ready", 32'(bif.cpu_ready), 0);
      end
      chk("err_conflict", 32'(bus_err), 1);
      bif.cpu_rd = 1'b0; bif.cpu_wr = 1'b0;
      resad = 8'h80;
      @(negedge clk);
      chk("resdt_status", 32'(resdt), 32'h04);
      resad = 8'h81;
      @(negedge clk);
      chk("resdt_adr", 32'(resdt), 32'hF4);

      // Zero wait states: pre-write RAM, then a continuously held read sweep
      for (int i = 0; i < 4; i++) acc0(1'b0, 8'(i), held_data[i], 8'h00);
      @(negedge clk);
      bif0.cpu_adrs = 8'h00; bif0.cpu_rd = 1'b1;
      for (int i = 0; i < 4; i++) exp0_q.push_back(held_data[i]);
      last_rd0 = held_data[3];
      for (int i = 0; i < 4; i++) begin
         int n;
         n = 0;
         do begin @(negedge clk); n++; end while (!bif0.cpu_ready && n < 10);
         chk("held_period", n, (i == 0) ? 1 : 2);
         bif0.cpu_adrs = 8'(i + 1);
      end
      bif0.cpu_rd = 1'b0;

      // Reset during the wait state of an I/O write
      @(negedge clk);
      bif.cpu_adrs = 8'hF0; bif.cpu_wdata = 8'h99; bif.cpu_wr = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      bif.cpu_wr = 1'b0;
      #1;
      chk("rstw_ready", 32'(bif.cpu_ready), 0);
      chk("rstw_rdata", 32'(bif.cpu_rdata), 0);
      chk("rstw_io_out", io_out, 0);
      chk("rstw_wstb", 32'(io_wstb), 0);
      chk("rstw_bus_err", 32'(bus_err), 0);
      chk("rstw_resdt", 32'(resdt), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rstw_io_out0", 32'(io_out[7:0]), 0);
      chk("sb_empty0", exp0_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
